// File: rtl/fp32div_if.sv
// Operand/result handshake bundle for the iterative fp32 divider.
// The master drives operands and the start strobe; the divider returns the result and status.
interface fp32div_if;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        en;
    logic [31:0] y;
    logic        ready;
    logic        busy;

    modport master (output x1, x2, en, input y, ready, busy);
    modport slave  (input x1, x2, en, output y, ready, busy);
endinterface

// File: rtl/fp32div.sv
// Iterative binary32 divider: restoring mantissa division, one quotient bit per clock,
// then a single normalise/pack cycle. Truncating, no denormal output, fixed 26-clock latency.
module fp32div #(
    parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
    input  logic     clk,
    input  logic     rst,
    fp32div_if.slave bus
);
    localparam int ITER = 25;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] NORM = 2'd2;

    logic [1:0]  state;
    logic        sign;
    logic [7:0]  e1, e2;
    logic [24:0] rem;
    logic [23:0] d;
    logic [24:0] q;
    logic [4:0]  cnt;
    logic        nan_f, dz_f, z_f;
    logic [31:0] y_r;
    logic        ready_r, busy_r;

    // Restoring step: remainder stays below 2*d, so 25 bits hold the shifted value.
    logic        rem_ge;
    logic [24:0] rem_sub;
    assign rem_ge  = rem >= {1'b0, d};
    assign rem_sub = rem - {1'b0, d};

    logic signed [9:0] expw, exp_n;
    logic [22:0]       frac;
    logic [31:0]       result;

    always_comb begin
        expw  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
        exp_n = q[24] ? expw : expw - 10'sd1;
        frac  = q[24] ? q[23:1] : q[22:0];
        result = {sign, exp_n[7:0], frac};
        if (exp_n >= 10'sd255)
            result = {sign, 8'hFF, 23'h0};
        else if (exp_n <= 10'sd0)
            result = {sign, 31'h0};
        // Special operands take precedence over the computed quotient.
        if (nan_f)
            result = NAN_VALUE;
        else if (dz_f)
            result = {sign, 8'hFF, 23'h0};
        else if (z_f)
            result = {sign, 31'h0};
    end

    // NOTE: all state updates here use non-blocking assignments so every register
    // samples the pre-edge values, avoiding order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sign    <= 1'b0;
            e1      <= 8'h0;
            e2      <= 8'h0;
            rem     <= 25'h0;
            d       <= 24'h0;
            q       <= 25'h0;
            cnt     <= 5'h0;
            nan_f   <= 1'b0;
            dz_f    <= 1'b0;
            z_f     <= 1'b0;
            y_r     <= 32'h0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        sign   <= bus.x1[31] ^ bus.x2[31];
                        e1     <= bus.x1[30:23];
                        e2     <= bus.x2[30:23];
                        rem    <= {2'b01, bus.x1[22:0]};
                        d      <= {1'b1, bus.x2[22:0]};
                        q      <= 25'h0;
                        cnt    <= 5'h0;
                        nan_f  <= (bus.x1[30:23] == 8'hFF) || (bus.x2[30:23] == 8'hFF);
                        dz_f   <= bus.x2[30:23] == 8'h00;
                        z_f    <= bus.x1[30:23] == 8'h00;
                        busy_r <= 1'b1;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    if (rem_ge) begin
                        q   <= {q[23:0], 1'b1};
                        rem <= {rem_sub[23:0], 1'b0};
                    end else begin
                        q   <= {q[23:0], 1'b0};
                        rem <= {rem[23:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1))
                        state <= NORM;
                end
                NORM: begin
                    y_r     <= result;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.y     = y_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
endmodule

// File: tb/tb_fp32div.sv
// Directed bench for fp32div: table of hand-computed quotients plus busy-rule
// and mid-operation reset sequences.
module tb_fp32div;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32div_if bus();
    fp32div dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture one division, scramble the operands afterwards, and check latency/result.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] want, input string name);
        int at;
        at = -1;
        bus.x1 = a;
        bus.x2 = b;
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        check({name, " busy_start"}, 32'(bus.busy), 32'd1);
        bus.x1 = ~a;
        bus.x2 = ~b;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 25)
                check({name, " busy_e25"}, 32'(bus.busy), 32'd1);
            if (bus.ready) begin
                at = n;
                break;
            end
        end
        check({name, " latency"}, 32'(at), 32'd26);
        check({name, " y"}, bus.y, want);
        check({name, " busy_end"}, 32'(bus.busy), 32'd0);
        tick();
        check({name, " ready_pulse"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin
        int ready_cnt;
        int r1;
        int r2;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, "6/2"};
        vecs[1]  = '{32'hC1000000, 32'h40000000, 32'hC0800000, "-8/2"};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, "1/3"};
        vecs[3]  = '{32'h41100000, 32'h40400000, 32'h40400000, "9/3"};
        vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, "1/0"};
        vecs[5]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, "-1/0"};
        vecs[6]  = '{32'h00000000, 32'h40000000, 32'h00000000, "0/2"};
        vecs[7]  = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, "inf/1"};
        vecs[8]  = '{32'h3F800000, 32'h7F800000, 32'h7FC00000, "1/inf"};
        vecs[9]  = '{32'h00000000, 32'h00000000, 32'h7F800000, "0/0"};
        vecs[10] = '{32'h7F000000, 32'h00800000, 32'h7F800000, "overflow"};
        vecs[11] = '{32'h00800000, 32'h7F000000, 32'h00000000, "underflow"};
        vecs[12] = '{32'h80000000, 32'h40000000, 32'h80000000, "-0/2"};
        vecs[13] = '{32'h00400000, 32'h3F800000, 32'h00000000, "denorm/1"};

        rst    = 1'b1;
        bus.en = 1'b0;
        bus.x1 = 32'h0;
        bus.x2 = 32'h0;
        tick();
        tick();
        check("reset y", bus.y, 32'h0);
        check("reset ready", 32'(bus.ready), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++)
            run_div(vecs[i].a, vecs[i].b, vecs[i].want, vecs[i].name);

        // en during DIV (edge 5) and NORM (edge 26) ignored; en at edge 27 accepted.
        ready_cnt = 0;
        r1 = -1;
        r2 = -1;
        bus.x1 = 32'h40C00000;
        bus.x2 = 32'h40000000;
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            bus.en = (k == 5) || (k == 26) || (k == 27);
            if (bus.en) begin
                bus.x1 = 32'h41100000;
                bus.x2 = 32'h40400000;
            end
            tick();
            bus.en = 1'b0;
            if (bus.ready) begin
                ready_cnt++;
                if (ready_cnt == 1) begin
                    r1 = k;
                    check("busy_seq y1", bus.y, 32'h40400000);
                end else if (ready_cnt == 2) begin
                    r2 = k;
                    check("busy_seq y2", bus.y, 32'h40400000);
                end
            end
        end
        check("busy_seq ready_count", 32'(ready_cnt), 32'd2);
        check("busy_seq first_ready", 32'(r1), 32'd26);
        check("busy_seq second_ready", 32'(r2), 32'd53);

        // Reset at edge 10 of a divide: outputs clear and no ready ever appears.
        bus.x1 = 32'h3F800000;
        bus.x2 = 32'h40400000;
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        for (int k = 1; k <= 9; k++)
            tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset y", bus.y, 32'h0);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset ready", 32'(bus.ready), 32'd0);
        ready_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.ready)
                ready_cnt++;
        end
        check("midreset no_ready", 32'(ready_cnt), 32'd0);
        run_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, "after_reset 1/3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
